// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - calculator control FSM: operand/opcode capture, settle-and-latch, scan mode
// Drives op_a/op_b/sel into the result multiplexer and latches its output for display.
module calc_sequencer #(
  parameter int SETTLE = 2,
  parameter int HOLD   = 50000000,
  parameter int HOLD_W = 26
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_enter,
  input  logic        i_btn_scan,
  input  logic [4:0]  i_data_in,
  input  logic [11:0] i_mux_out,
  output logic [4:0]  o_op_a,
  output logic [4:0]  o_op_b,
  output logic [2:0]  o_sel,
  output logic [11:0] o_result,
  output logic        o_result_valid,
  output logic        o_busy,
  output logic [2:0]  o_state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_B  = 3'd1,
    S_GET_OP = 3'd2,
    S_SETTLE = 3'd3,
    S_DONE   = 3'd4,
    S_SCAN   = 3'd5
  } state_t;

  localparam logic [3:0]        SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [HOLD_W-1:0] HOLD_M1   = HOLD_W'(HOLD - 1);
  localparam logic [HOLD_W-1:0] SCAN_CAP  = HOLD_W'(SETTLE - 1);

  state_t              r_state;
  logic                r_enter_q;
  logic                r_scan_q;
  logic [3:0]          r_cnt;
  logic [HOLD_W-1:0]   r_hold;
  logic [4:0]          r_op_a;
  logic [4:0]          r_op_b;
  logic [2:0]          r_sel;
  logic [11:0]         r_result;
  logic                r_result_valid;
  logic                r_busy;

  logic w_enter_ev;
  logic w_scan_ev;

  assign w_enter_ev = i_btn_enter & ~r_enter_q;
  assign w_scan_ev  = i_btn_scan & ~r_scan_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      // History starts high so a button held through reset yields no event
      r_enter_q      <= 1'b1;
      r_scan_q       <= 1'b1;
      r_cnt          <= '0;
      r_hold         <= '0;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_sel          <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_enter_q <= i_btn_enter;
      r_scan_q  <= i_btn_scan;
      case (r_state)
        S_IDLE: begin
          if (w_enter_ev) begin
            r_op_a         <= i_data_in;
            r_result_valid <= 1'b0;
            r_state        <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (w_enter_ev) begin
            r_op_b  <= i_data_in;
            r_state <= S_GET_OP;
          end
        end
        S_GET_OP: begin
          if (w_enter_ev && (i_data_in[2:0] != 3'd7)) begin
            r_sel   <= i_data_in[2:0];
            r_cnt   <= SETTLE_M1;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_result       <= i_mux_out;
            r_result_valid <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (w_enter_ev) begin
            r_result_valid <= 1'b0;
            r_state        <= S_IDLE;
          end else if (w_scan_ev) begin
            r_sel          <= 3'd0;
            r_hold         <= '0;
            r_result_valid <= 1'b0;
            r_state        <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Leaving on enter freezes sel/result and pre-empts any rollover
          if (w_enter_ev) begin
            r_state <= S_DONE;
          end else if (r_hold == HOLD_M1) begin
            r_hold         <= '0;
            r_result_valid <= 1'b0;
            r_sel          <= (r_sel == 3'd6) ? 3'd0 : r_sel + 3'd1;
          end else begin
            r_hold <= r_hold + 1'b1;
            if (r_hold == SCAN_CAP) begin
              r_result       <= i_mux_out;
              r_result_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_op_a         = r_op_a;
  assign o_op_b         = r_op_b;
  assign o_sel          = r_sel;
  assign o_result       = r_result;
  assign o_result_valid = r_result_valid;
  assign o_busy         = r_busy;
  assign o_state_dbg    = r_state;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_enter = 1'b0;
  logic        btn_scan = 1'b0;
  logic [4:0]  data_in = 5'd0;
  logic [11:0] mux_out;
  logic [4:0]  op_a, op_b;
  logic [2:0]  sel;
  logic [11:0] result;
  logic        result_valid, busy;
  logic [2:0]  state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  calc_sequencer #(.SETTLE(2), .HOLD(4), .HOLD_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_btn_enter(btn_enter), .i_btn_scan(btn_scan),
    .i_data_in(data_in), .i_mux_out(mux_out), .o_op_a(op_a), .o_op_b(op_b),
    .o_sel(sel), .o_result(result), .o_result_valid(result_valid),
    .o_busy(busy), .o_state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] mux_model(input logic [4:0] a, input logic [4:0] b,
                                             input logic [2:0] s);
    case (s)
      3'd0: mux_model = 12'(a) + 12'(b);
      3'd1: mux_model = 12'(a) - 12'(b);
      3'd2: mux_model = 12'(a) * 12'(b);
      3'd3: mux_model = {7'd0, ~a};
      3'd4: mux_model = {7'd0, ~b};
      3'd5: mux_model = {2'd0, a, b};
      3'd6: mux_model = {9'd0, a > b, a == b, a < b};
      default: mux_model = 12'd0;
    endcase
  endfunction

  assign mux_out = mux_model(op_a, op_b, sel);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic press_enter(input logic [4:0] d);
    @(posedge clk); #1;
    data_in = d;
    btn_enter = 1'b1;
    @(posedge clk); #1;
    btn_enter = 1'b0;
  endtask

  task automatic run_calc(input logic [4:0] a, input logic [4:0] b, input logic [2:0] op,
                          input logic [11:0] exp);
    press_enter(a);
    check("op_a captured", op_a, a);
    check("state GET_B", state_dbg, 1);
    press_enter(b);
    check("op_b captured", op_b, b);
    check("state GET_OP", state_dbg, 2);
    press_enter({2'b00, op});
    check("state SETTLE", state_dbg, 3);
    check("sel driven", sel, op);
    check("busy edge0", busy, 1);
    check("rv edge0", result_valid, 0);
    @(posedge clk); #1;
    check("busy edge1", busy, 1);
    check("rv edge1", result_valid, 0);
    @(posedge clk); #1;
    check("rv edge2", result_valid, 1);
    check("result", result, exp);
    check("state DONE", state_dbg, 4);
    check("busy after", busy, 0);
  endtask

  typedef struct {
    logic [4:0]  a;
    logic [4:0]  b;
    logic [2:0]  op;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[7];
  logic [11:0] exp_scan[7];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{5'd5,  5'd3,  3'd0, 12'd8};
    vecs[1] = '{5'd31, 5'd31, 3'd2, 12'd961};
    vecs[2] = '{5'd9,  5'd4,  3'd1, 12'd5};
    vecs[3] = '{5'd6,  5'd2,  3'd5, 12'd194};
    vecs[4] = '{5'd10, 5'd3,  3'd3, 12'd21};
    vecs[5] = '{5'd1,  5'd2,  3'd4, 12'd29};
    vecs[6] = '{5'd7,  5'd7,  3'd6, 12'd2};
    // a=4, b=2 through ops 0..6
    exp_scan = '{12'd6, 12'd2, 12'd8, 12'd27, 12'd29, 12'd130, 12'd4};

    repeat (2) @(posedge clk);
    #1;
    check("reset state", state_dbg, 0);
    check("reset op_a", op_a, 0);
    check("reset sel", sel, 0);
    check("reset result", result, 0);
    check("reset rv", result_valid, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        press_enter(5'd0);
        check("return IDLE", state_dbg, 0);
        check("return rv", result_valid, 0);
      end
      run_calc(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    end

    press_enter(5'd0);
    press_enter(5'd4);
    press_enter(5'd2);
    press_enter(5'b00111);
    check("invalid op state", state_dbg, 2);
    check("invalid op sel", sel, 6);
    check("invalid op busy", busy, 0);
    press_enter(5'd6);
    check("op6 state", state_dbg, 3);
    check("op6 sel", sel, 6);
    repeat (2) @(posedge clk);
    #1;
    check("op6 result", result, 4);
    check("op6 rv", result_valid, 1);

    @(posedge clk); #1;
    btn_scan = 1'b1;
    @(posedge clk); #1;
    btn_scan = 1'b0;
    check("scan state", state_dbg, 5);
    check("scan sel0", sel, 0);
    check("scan rv0", result_valid, 0);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
      check("scan sel", sel, (k / 4) % 7);
      check("scan rv", result_valid, (k % 4) >= 2);
      if ((k % 4) >= 2)
        check("scan result", result, exp_scan[(k / 4) % 7]);
    end
    btn_enter = 1'b1;
    @(posedge clk); #1;
    btn_enter = 1'b0;
    check("scan exit state", state_dbg, 4);
    check("scan exit sel", sel, 1);
    check("scan exit rv", result_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    check("frozen sel", sel, 1);
    check("frozen state", state_dbg, 4);
    check("frozen result", result, 2);

    btn_enter = 1'b1;
    btn_scan = 1'b1;
    @(posedge clk); #1;
    btn_enter = 1'b0;
    btn_scan = 1'b0;
    check("simul state", state_dbg, 0);
    check("simul rv", result_valid, 0);

    press_enter(5'd3);
    press_enter(5'd1);
    press_enter(5'd0);
    check("pre-reset state", state_dbg, 3);
    #2;
    btn_enter = 1'b1;
    rst = 1'b1;
    #1;
    check("async rst state", state_dbg, 0);
    check("async rst op_a", op_a, 0);
    check("async rst op_b", op_b, 0);
    check("async rst sel", sel, 0);
    check("async rst result", result, 0);
    check("async rst busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    data_in = 5'd17;
    repeat (3) @(posedge clk);
    #1;
    check("held btn state", state_dbg, 0);
    check("held btn op_a", op_a, 0);
    btn_enter = 1'b0;
    data_in = 5'd9;
    @(posedge clk); #1;
    btn_enter = 1'b1;
    @(posedge clk); #1;
    btn_enter = 1'b0;
    check("re-press op_a", op_a, 9);
    check("re-press state", state_dbg, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
